// File: rtl/ram_sched_pkg.sv
// ram_sched_pkg: read-tag type and round-robin picker shared by the RAM scheduler.
// Tag index is sized for up to MAX_RD requesters so one package serves any N_RD.
package ram_sched_pkg;
  localparam int MAX_RD = 64;
  localparam int IDX_W  = 6;
  typedef struct packed {
    logic             val;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;
  // First set bit of req at or after ptr, wrapping at n; returns ptr if req is empty.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_RD-1:0] req,
                                               input logic [IDX_W-1:0] ptr, input int n);
    logic found;
    int   j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_RD; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !found && req[j]) begin
        rr_pick = IDX_W'(j);
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register of read tags, decoded to a one-hot valid
// at the final stage so returning RAM data is steered to the requester that issued it.
module rd_tag_pipe
  import ram_sched_pkg::*;
#(
  parameter int N_RD  = 4,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  rd_tag_t         tag_i,
  output logic [N_RD-1:0] val_o
);
  rd_tag_t r_stage [DEPTH];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= tag_i;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end
  assign val_o = {{(N_RD-1){1'b0}}, r_stage[DEPTH-1].val} << r_stage[DEPTH-1].idx;
endmodule

// File: rtl/ram_rd_wr_sched.sv
// ram_rd_wr_sched: shares one single-port RAM between a write port and N_RD round-robin readers.
// Define RAM_RD_WR_SCHED_OUT_REG_EN to register rd_data_o/rd_data_val_o (latency RAM_LATENCY+1).
module ram_rd_wr_sched
  import ram_sched_pkg::*;
#(
  parameter int N_RD        = 4,
  parameter int AW          = 10,
  parameter int DW          = 64,
  parameter int RAM_LATENCY = 2,
  parameter int MAX_WR_RUN  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_RD-1:0]          rd_req_i,
  input  logic [N_RD-1:0][AW-1:0]  rd_addr_i,
  output logic [N_RD-1:0]          rd_ready_o,
  output logic [DW-1:0]            rd_data_o,
  output logic [N_RD-1:0]          rd_data_val_o,
  input  logic                     wr_req_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [DW-1:0]            wr_data_i,
  output logic                     wr_ready_o,
  output logic                     ram_rd_en_o,
  output logic [AW-1:0]            ram_rd_addr_o,
  input  logic [DW-1:0]            ram_rd_data_i,
  output logic                     ram_wr_en_o,
  output logic [AW-1:0]            ram_wr_addr_o,
  output logic [DW-1:0]            ram_wr_data_o
);
  localparam int GW = $clog2(N_RD);
  localparam int RW = $clog2(MAX_WR_RUN + 1);
  logic [GW-1:0]   r_rr_ptr;
  logic [RW-1:0]   r_wr_run;
  logic            w_rd_any, w_wr_win, w_rd_win;
  logic [GW-1:0]   w_g;
  logic [N_RD-1:0] w_val;
  rd_tag_t         w_tag;
  // Writes win unless they have used up their run while a read is waiting.
  assign w_rd_any      = |rd_req_i;
  assign w_wr_win      = wr_req_i & ~((r_wr_run == RW'(MAX_WR_RUN)) & w_rd_any);
  assign w_rd_win      = ~w_wr_win & w_rd_any;
  assign w_g           = GW'(rr_pick(MAX_RD'(rd_req_i), IDX_W'(r_rr_ptr), N_RD));
  assign wr_ready_o    = w_wr_win;
  assign ram_wr_en_o   = w_wr_win;
  assign ram_wr_addr_o = wr_addr_i;
  assign ram_wr_data_o = wr_data_i;
  assign rd_ready_o    = {{(N_RD-1){1'b0}}, w_rd_win} << w_g;
  assign ram_rd_en_o   = w_rd_win;
  assign ram_rd_addr_o = rd_addr_i[w_g];
  assign w_tag.val     = w_rd_win;
  assign w_tag.idx     = IDX_W'(w_g);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rr_ptr <= '0;
      r_wr_run <= '0;
    end else begin
      if (w_rd_win) r_rr_ptr <= (w_g == GW'(N_RD - 1)) ? '0 : w_g + 1'b1;
      r_wr_run <= !w_wr_win ? '0 : (r_wr_run == RW'(MAX_WR_RUN)) ? r_wr_run : r_wr_run + 1'b1;
    end
  end
  rd_tag_pipe #(.N_RD(N_RD), .DEPTH(RAM_LATENCY)) u_tag_pipe (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .tag_i  (w_tag),
    .val_o  (w_val)
  );
`ifdef RAM_RD_WR_SCHED_OUT_REG_EN
  logic [DW-1:0]   r_rd_data;
  logic [N_RD-1:0] r_rd_val;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_data <= '0;
      r_rd_val  <= '0;
    end else begin
      r_rd_val <= w_val;
      if (|w_val) r_rd_data <= ram_rd_data_i;
    end
  end
  assign rd_data_o     = r_rd_data;
  assign rd_data_val_o = r_rd_val;
`else
  assign rd_data_o     = ram_rd_data_i;
  assign rd_data_val_o = w_val;
`endif
endmodule

// File: doc/ram_rd_wr_sched.md
Name: ram_rd_wr_sched

Overview:
- Schedules one single-port, fixed-latency RAM (one read or one write per cycle) between one write requester and N_RD read requesters.
- Writes have priority over reads, bounded by a fairness limit. Reads are arbitrated round-robin.
- Each read is tagged with its requester index. The tag travels down a RAM_LATENCY-deep pipeline so the returned data's valid strobe goes to the requester that issued the read.
- Sits between the hash-table lookup/insert engines and the bucket RAM.

Parameters:
- N_RD, 4, number of read requesters (>=2).
- AW, 10, RAM address width.
- DW, 64, RAM data width.
- RAM_LATENCY, 2, cycles from ram_rd_en_o high to ram_rd_data_i valid (>=1).
- MAX_WR_RUN, 4, maximum consecutive write grants while any read is pending (>=1).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous reset, active low
- rd_req_i  in  N_RD  per-requester read request (valid)
- rd_addr_i  in  N_RD x AW  per-requester read address
- rd_ready_o  out  N_RD  one-hot read grant; request accepted when rd_req_i & rd_ready_o
- rd_data_o  out  DW  read data, broadcast to all requesters
- rd_data_val_o  out  N_RD  one-hot; qualifies rd_data_o for the owning requester
- wr_req_i  in  1  write request
- wr_addr_i  in  AW  write address
- wr_data_i  in  DW  write data
- wr_ready_o  out  1  write grant
- ram_rd_en_o  out  1  RAM read strobe
- ram_rd_addr_o  out  AW  RAM read address
- ram_rd_data_i  in  DW  RAM read data
- ram_wr_en_o  out  1  RAM write strobe
- ram_wr_addr_o  out  AW  RAM write address
- ram_wr_data_o  out  DW  RAM write data

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_n_i is asynchronous, active low.
- Reset values:
  - rr_ptr=0, wr_run=0, tag pipeline all invalid.
  - rd_data_val_o=0.
  - rd_data_o=0 when the output register is present.
- Grant logic (combinational, same cycle as request):
  - wr_win = wr_req_i & ~(wr_run==MAX_WR_RUN & |rd_req_i).
  - wr_ready_o = wr_win.
  - ram_wr_en_o = wr_win; ram_wr_addr_o/ram_wr_data_o pass through wr_addr_i/wr_data_i.
  - If ~wr_win and |rd_req_i: grant the first requesting index at or after rr_ptr, wrapping modulo N_RD.
  - Granted read: rd_ready_o[g]=1, ram_rd_en_o=1, ram_rd_addr_o=rd_addr_i[g].
  - ram_rd_en_o and ram_wr_en_o are never high together. At most one rd_ready_o bit is high.
  - Address outputs are don't-care when their enable is low; implement as muxes, not gated.
- rr_ptr: on a read grant g, rr_ptr <= (g==N_RD-1) ? 0 : g+1. Otherwise it holds.
- wr_run:
  - Increments on a write grant, saturating at MAX_WR_RUN.
  - Clears to 0 on any read grant, or on any cycle with no write grant.
  - With no read pending, writes stream indefinitely (wr_run saturates; no stall).
- Tag pipeline:
  - Stage 1 <= {ram_rd_en_o, g}. Stage k <= stage k-1 for k = 2..RAM_LATENCY.
  - Stage RAM_LATENCY valid drives rd_data_val_o[tag] = 1, with rd_data_o = ram_rd_data_i.
  - Total read latency = RAM_LATENCY cycles from the accept cycle.
  - Back-to-back reads are supported every cycle; no bubbles.
- Read-after-write: a read accepted in the cycle after a write sees the new data; the RAM is assumed write-first.
- Reset mid-operation: all in-flight tags are discarded. No rd_data_val_o pulses after reset release for reads accepted before reset.
- Requesters must hold rd_req_i/rd_addr_i stable until accepted.
- There is no cancellation.

Optional Feature:
- Macro: RAM_RD_WR_SCHED_OUT_REG_EN.
- Defined:
  - rd_data_o and rd_data_val_o are registered once more.
  - Read latency = RAM_LATENCY+1.
  - rd_data_o resets to 0 and holds its last value when not valid.
- Undefined:
  - rd_data_o is combinationally ram_rd_data_i.
  - rd_data_val_o comes directly from the last tag stage.
  - Read latency = RAM_LATENCY.

Decomposition:
- Package ram_sched_pkg:
  - typedef rd_tag_t = struct {logic val; logic [$clog2(N_RD)-1:0] idx;}.
  - Function rr_pick(req, ptr) returning the grant index.
- Sub-module rd_tag_pipe: a RAM_LATENCY-stage shift register of rd_tag_t with async active-low reset, producing the one-hot valid output.

Test Plan:
- Single read, RAM_LATENCY=2: rd_req_i[2]=1, addr 0x05 at cycle 0.
  - rd_ready_o=4'b0100 at cycle 0.
  - rd_data_val_o=4'b0100 at cycle 2 with RAM[5].
  - With OUT_REG_EN: cycle 3.
- Round-robin: all four read requesters held high for 8 cycles, no writes.
  - Grants 0,1,2,3,0,1,2,3.
  - Data valids follow in the same order, 2 cycles later.
- Write fairness, MAX_WR_RUN=4: wr_req_i and rd_req_i[1] held high.
  - Pattern W,W,W,W,R1 repeating.
  - rd_req_i low: continuous writes.
- Read-after-write: write 0xABCD to addr 7 at cycle 0; read addr 7 on requester 0 at cycle 1.
  - rd_data_o=0xABCD with rd_data_val_o[0] at cycle 3.
- Reset mid-flight: reads granted at cycles 0 and 1; rst_n_i low at cycle 1.5, released at cycle 3.
  - rd_data_val_o stays 0 through cycle 6.
  - rr_ptr restarts at 0.
- Mutual exclusion: random requests for 10k cycles.
  - Assert never (ram_rd_en_o & ram_wr_en_o).
  - Assert $onehot0(rd_ready_o).
  - Every accepted read produces exactly one valid to its own index.
